// File: rtl/alu_mdu.sv
// alu_mdu: single-issue integer ALU with an iterative multiply/divide unit.
// Base ops complete one cycle after acceptance; M ops iterate one bit per
// cycle for XLEN cycles. Define ALU_MDU_DIV_EN to compile in the restoring
// divider (DIV/DIVU/REM/REMU); without it those codes return 0 as base ops.
module alu_mdu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] lhs,
  input  logic [XLEN-1:0] rhs,
  input  logic [4:0]      funct,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] LAST = SHW'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [XLEN-1:0]   r_out;
  logic [SHW-1:0]    r_cnt;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_mcand;
  logic [2:0]        r_op;
  logic              r_neg_q;
`ifdef ALU_MDU_DIV_EN
  logic              r_neg_r;
`endif

  logic              w_accept;
  logic              w_start_iter;
  logic              w_last;
  logic [SHW-1:0]    w_shamt;
  logic [XLEN-1:0]   w_base;
  logic              w_lhs_signed;
  logic              w_rhs_signed;
  logic              w_lhs_neg;
  logic              w_rhs_neg;
  logic [XLEN-1:0]   w_lhs_mag;
  logic [XLEN-1:0]   w_rhs_mag;
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN-1:0]   w_hi_nxt;
  logic [XLEN-1:0]   w_lo_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_c;
  logic [XLEN-1:0]   w_mres;
`ifdef ALU_MDU_DIV_EN
  logic [XLEN:0]     w_rem_sh;
  logic              w_ge;
  logic [XLEN-1:0]   w_diff;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out       = r_out;

  assign w_accept = in_valid & r_in_ready;
  assign w_last   = (r_cnt == LAST);
  assign w_shamt  = rhs[SHW-1:0];
`ifdef ALU_MDU_DIV_EN
  assign w_start_iter = funct[4];
`else
  assign w_start_iter = funct[4] & ~funct[2];
`endif

  // Base (single-cycle) operation result.
  always_comb begin
    w_base = '0;
    case (funct[3:0])
      4'b0000: w_base = lhs & rhs;
      4'b0001: w_base = lhs | rhs;
      4'b0010: w_base = lhs ^ rhs;
      4'b0011: w_base = lhs + rhs;
      4'b1011: w_base = lhs - rhs;
      4'b0100: w_base = lhs >> w_shamt;
      4'b1100: w_base = XLEN'($signed(lhs) >>> w_shamt);
      4'b0101: w_base = lhs << w_shamt;
      4'b0110: w_base = XLEN'(lhs < rhs);
      4'b1110: w_base = XLEN'($signed(lhs) < $signed(rhs));
      default: w_base = '0;
    endcase
  end

  // Operand signedness and magnitudes for M ops at acceptance.
  always_comb begin
    w_lhs_signed = (funct[2:0] == 3'b001) | (funct[2:0] == 3'b010) |
                   (funct[2:0] == 3'b100) | (funct[2:0] == 3'b110);
    w_rhs_signed = (funct[2:0] == 3'b001) | (funct[2:0] == 3'b100) |
                   (funct[2:0] == 3'b110);
    w_lhs_neg    = w_lhs_signed & lhs[XLEN-1];
    w_rhs_neg    = w_rhs_signed & rhs[XLEN-1];
    w_lhs_mag    = w_lhs_neg ? -lhs : lhs;
    w_rhs_mag    = w_rhs_neg ? -rhs : rhs;
  end

  // One iteration: shift-add multiply step or restoring divide step.
  always_comb begin
    w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
    w_hi_nxt  = w_mul_sum[XLEN:1];
    w_lo_nxt  = {w_mul_sum[0], r_lo[XLEN-1:1]};
`ifdef ALU_MDU_DIV_EN
    w_rem_sh  = {r_hi, r_lo[XLEN-1]};
    w_ge      = (w_rem_sh >= {1'b0, r_mcand});
    w_diff    = w_rem_sh[XLEN-1:0] - r_mcand;
    if (r_op[2]) begin
      w_hi_nxt = w_ge ? w_diff : w_rem_sh[XLEN-1:0];
      w_lo_nxt = {r_lo[XLEN-2:0], w_ge};
    end
`endif
  end

  // Final-iteration result with sign correction applied.
  always_comb begin
    w_prod   = {w_hi_nxt, w_lo_nxt};
    w_prod_c = r_neg_q ? -w_prod : w_prod;
    w_mres   = '0;
    case (r_op)
      3'b000:                 w_mres = w_prod_c[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_mres = w_prod_c[2*XLEN-1:XLEN];
`ifdef ALU_MDU_DIV_EN
      3'b100, 3'b101:         w_mres = r_neg_q ? -w_lo_nxt : w_lo_nxt;
      default:                w_mres = r_neg_r ? -w_hi_nxt : w_hi_nxt;
`else
      default:                w_mres = '0;
`endif
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_start_iter ? S_BUSY : S_DONE;
      S_BUSY:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; in_ready tracks the IDLE state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt == S_IDLE);
    end
  end

  // Operand capture, iteration datapath and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_cnt       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_mcand     <= '0;
      r_op        <= '0;
      r_neg_q     <= 1'b0;
`ifdef ALU_MDU_DIV_EN
      r_neg_r     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= w_lhs_mag;
            r_mcand <= w_rhs_mag;
            r_op    <= funct[2:0];
`ifdef ALU_MDU_DIV_EN
            r_neg_q <= (w_lhs_neg ^ w_rhs_neg) & ~(funct[2] & (rhs == '0));
            r_neg_r <= w_lhs_neg;
`else
            r_neg_q <= w_lhs_neg ^ w_rhs_neg;
`endif
            if (!w_start_iter) begin
              r_out       <= funct[4] ? '0 : w_base;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt + SHW'(1);
          if (w_last) begin
            r_out       <= w_mres;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed testbench for alu_mdu (XLEN=32). Divider vectors are compiled in
// when ALU_MDU_DIV_EN is defined; otherwise divide codes are checked as zero.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] lhs;
  logic [31:0] rhs;
  logic [4:0]  funct;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [4:0] F_AND = 5'b00000, F_OR = 5'b00001, F_XOR = 5'b00010,
                         F_ADD = 5'b00011, F_SUB = 5'b01011, F_SRL = 5'b00100,
                         F_SRA = 5'b01100, F_SLL = 5'b00101, F_SLTU = 5'b00110,
                         F_SLT = 5'b01110, F_UND = 5'b00111,
                         F_MUL = 5'b10000, F_MULH = 5'b10001, F_MULHSU = 5'b10010,
                         F_MULHU = 5'b10011, F_DIV = 5'b10100, F_DIVU = 5'b10101,
                         F_REM = 5'b10110, F_REMU = 5'b10111;

  alu_mdu #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lhs       (lhs),
    .rhs       (rhs),
    .funct     (funct),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble inputs after acceptance, wait for the result,
  // optionally hold it for some cycles while poking in_valid, then retire it.
  task automatic run_op(input string tag, input logic [4:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_v,
                        input int exp_lat, input int hold);
    int lat;
    bit rdy_seen;
    @(negedge clk);
    in_valid = 1'b1; funct = f; lhs = a; rhs = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0; funct = ~f; lhs = ~a; rhs = b ^ 32'h5a5a_a5a5;
    lat = 1;
    rdy_seen = 1'b0;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (in_ready) rdy_seen = 1'b1;
    check({tag, "_val"}, 64'(out), 64'(exp_v));
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_rdy_low"}, 64'(rdy_seen), 64'd0);
    if (hold > 0) begin
      bit unstable;
      unstable = 1'b0;
      for (int i = 0; i < hold; i++) begin
        in_valid = i[0]; funct = F_ADD; lhs = 32'd100; rhs = 32'd23;
        @(negedge clk);
        if (out !== exp_v || out_valid !== 1'b1 || in_ready !== 1'b0) unstable = 1'b1;
      end
      in_valid = 1'b0;
      check({tag, "_hold"}, 64'(unstable), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_retire"}, {62'd0, out_valid, in_ready}, 64'b01);
    if (hold > 0) begin
      @(negedge clk);
      check({tag, "_noqueue"}, {62'd0, out_valid, in_ready}, 64'b01);
    end
  endtask

  // Start an M op, assert reset during cycle rst_cyc, check the abort.
  task automatic reset_abort(input string tag, input logic [4:0] f,
                             input logic [31:0] a, input logic [31:0] b, input int rst_cyc);
    bit leaked;
    @(negedge clk);
    in_valid = 1'b1; funct = f; lhs = a; rhs = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (rst_cyc) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check({tag, "_rst_state"}, {31'd0, out_valid, in_ready, out}, {31'd0, 1'b0, 1'b1, 32'd0});
    leaked = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || out !== 32'd0) leaked = 1'b1;
    end
    check({tag, "_no_leak"}, 64'(leaked), 64'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    lhs = '0; rhs = '0; funct = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset", {31'd0, out_valid, in_ready, out}, {31'd0, 1'b0, 1'b1, 32'd0});

    run_op("sub",   F_SUB,  32'd5,          32'd7,          32'hFFFF_FFFE, 1, 0);
    run_op("sra",   F_SRA,  32'h8000_0000,  32'h0000_0024,  32'hF800_0000, 1, 0);
    run_op("and",   F_AND,  32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'h00F0_00F0, 1, 0);
    run_op("or",    F_OR,   32'h1234_0000,  32'h0000_5678,  32'h1234_5678, 1, 0);
    run_op("add",   F_ADD,  32'hFFFF_FFFF,  32'd2,          32'd1,         1, 0);
    run_op("srl",   F_SRL,  32'h8000_0000,  32'd31,         32'd1,         1, 0);
    run_op("sll",   F_SLL,  32'd1,          32'h0000_0021,  32'd2,         1, 0);
    run_op("sltu",  F_SLTU, 32'd1,          32'hFFFF_FFFF,  32'd1,         1, 0);
    run_op("slt0",  F_SLT,  32'd1,          32'hFFFF_FFFF,  32'd0,         1, 0);
    run_op("slt1",  F_SLT,  32'hFFFF_FFFF,  32'd1,          32'd1,         1, 0);
    run_op("undef", F_UND,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,         1, 0);
    run_op("xor_hold", F_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1, 5);

    run_op("mulh",   F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0);
    run_op("mul",    F_MUL,    32'd6,         32'd7,         32'd42,        33, 0);
    run_op("mulhu",  F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
    run_op("mulhsu", F_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33, 0);
    run_op("mulh_m1", F_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         33, 0);
    run_op("mul_lo", F_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         33, 0);
    run_op("mul_f3", 5'b11000, 32'd3,         32'd5,         32'd15,        33, 0);

`ifdef ALU_MDU_DIV_EN
    run_op("div_ovf",  F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 0);
    run_op("rem_ovf",  F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33, 0);
    run_op("divu_z",   F_DIVU, 32'd7,         32'd0,         32'hFFFF_FFFF, 33, 0);
    run_op("remu_z",   F_REMU, 32'd7,         32'd0,         32'd7,         33, 0);
    run_op("div_z",    F_DIV,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 33, 0);
    run_op("rem_z",    F_REM,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 33, 0);
    run_op("div_neg",  F_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 5);
    run_op("rem_neg",  F_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 0);
    run_op("divu",     F_DIVU, 32'd100,       32'd7,         32'd14,        33, 0);
    run_op("remu",     F_REMU, 32'd100,       32'd7,         32'd2,         33, 0);
    reset_abort("divu_abort", F_DIVU, 32'd1000, 32'd3, 10);
`else
    run_op("divu_off", F_DIVU, 32'd9,         32'd3,         32'd0,         1, 0);
    run_op("rem_off",  F_REM,  32'hFFFF_FFF9, 32'd2,         32'd0,         1, 0);
`endif
    reset_abort("mul_abort", F_MUL, 32'd1234, 32'd5678, 10);
    run_op("add_after_rst", F_ADD, 32'd1, 32'd2, 32'd3, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
